// File: rtl/crossbar_wb_ctrl.sv
// Wishbone-controlled pulse sequencer for the ReRAM crossbar: selects one cell,
// drives timed SET/RESET/READ enables and captures the sense comparator result.
module crossbar_wb_ctrl #(
  parameter int          ROWS      = 8,
  parameter int          COLS      = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic            sense_i,
  output logic [ROWS-1:0] row_sel,
  output logic [COLS-1:0] col_sel,
  output logic            set_en,
  output logic            rst_en,
  output logic            read_en,
  output logic            irq
);
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_RESET = 2'b10;
  localparam logic [1:0] OP_ILL   = 2'b11;
  localparam logic [4:0] LP_ROWS  = 5'(ROWS);
  localparam logic [4:0] LP_COLS  = 5'(COLS);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_CAPTURE, S_RELEASE
  } state_t;

  state_t      r_state, w_next;
  logic        r_ack;
  logic [1:0]  r_op;
  logic        r_irq_en;
  logic [3:0]  r_row, r_col;
  logic [15:0] r_pulse_w, r_settle;
  logic        r_done, r_err, r_sense;
  logic [15:0] r_count;
  logic [15:0] r_cnt;
  logic        r_sync1, r_sync2;

  logic        w_hit, w_wr, w_busy, w_start, w_bad, w_launch, w_cnt_zero, w_clr_done;
  logic [2:0]  w_idx;
  logic [1:0]  w_new_op;
  logic [31:0] w_rdata;
  logic        w_unused;

  function automatic logic [15:0] f_len(input logic [15:0] n);
    return (n == 16'd0) ? 16'd0 : n - 16'd1;
  endfunction

  assign w_hit      = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign w_idx      = wbs_adr_i[4:2];
  // Writes commit at the end of the ack cycle; the master holds the request until it sees ack.
  assign w_wr       = r_ack & wbs_stb_i & wbs_cyc_i & w_hit & wbs_we_i;
  assign w_busy     = (r_state != S_IDLE);
  assign w_new_op   = wbs_sel_i[0] ? wbs_dat_i[2:1] : r_op;
  assign w_start    = w_wr & (w_idx == 3'd0) & wbs_sel_i[0] & wbs_dat_i[0] & ~w_busy;
  assign w_bad      = (w_new_op == OP_ILL) | ({1'b0, r_row} >= LP_ROWS) |
                      ({1'b0, r_col} >= LP_COLS);
  assign w_launch   = w_start & ~w_bad;
  assign w_cnt_zero = (r_cnt == 16'd0);
  assign w_clr_done = w_wr & (w_idx == 3'd3) & wbs_sel_i[0] & wbs_dat_i[1];
  assign w_unused   = ^{wbs_adr_i[7:5], wbs_adr_i[1:0]};

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_launch)   w_next = S_SETUP;
      S_SETUP:   if (w_cnt_zero) w_next = S_PULSE;
      S_PULSE:   if (w_cnt_zero) w_next = (r_op == OP_READ) ? S_CAPTURE : S_RELEASE;
      S_CAPTURE: if (w_cnt_zero) w_next = S_RELEASE;
      S_RELEASE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset drops them at once.
  always_comb begin
    row_sel = '0;
    col_sel = '0;
    for (int i = 0; i < ROWS; i++) row_sel[i] = w_busy && (r_row == 4'(i));
    for (int j = 0; j < COLS; j++) col_sel[j] = w_busy && (r_col == 4'(j));
    set_en  = (r_state == S_PULSE) && (r_op == OP_SET);
    rst_en  = (r_state == S_PULSE) && (r_op == OP_RESET);
    read_en = ((r_state == S_PULSE) || (r_state == S_CAPTURE)) && (r_op == OP_READ);
  end

  // Phase counter holds cycles remaining minus one in the current timed state.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_cnt <= 16'd0;
    end else if (w_next != r_state) begin
      case (w_next)
        S_SETUP:   r_cnt <= f_len(r_settle);
        S_PULSE:   r_cnt <= f_len(r_pulse_w);
        S_CAPTURE: r_cnt <= 16'd1;
        default:   r_cnt <= 16'd0;
      endcase
    end else if (!w_cnt_zero) begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= sense_i;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_ack <= 1'b0;
    else          r_ack <= wbs_stb_i & wbs_cyc_i & w_hit & ~r_ack;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_op      <= 2'b00;
      r_irq_en  <= 1'b0;
      r_row     <= 4'd0;
      r_col     <= 4'd0;
      r_pulse_w <= 16'd0;
      r_settle  <= 16'd0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_sense   <= 1'b0;
      r_count   <= 16'd0;
    end else begin
      if (w_wr && !w_busy) begin
        case (w_idx)
          3'd0: if (wbs_sel_i[0]) begin
            r_op     <= wbs_dat_i[2:1];
            r_irq_en <= wbs_dat_i[3];
          end
          3'd1: begin
            if (wbs_sel_i[0]) r_row <= wbs_dat_i[3:0];
            if (wbs_sel_i[1]) r_col <= wbs_dat_i[11:8];
          end
          3'd2: begin
            if (wbs_sel_i[0]) r_pulse_w[7:0]  <= wbs_dat_i[7:0];
            if (wbs_sel_i[1]) r_pulse_w[15:8] <= wbs_dat_i[15:8];
            if (wbs_sel_i[2]) r_settle[7:0]   <= wbs_dat_i[23:16];
            if (wbs_sel_i[3]) r_settle[15:8]  <= wbs_dat_i[31:24];
          end
          default: ;
        endcase
      end
      // Completion outranks a same-cycle software clear of done.
      if (w_start) begin
        r_err  <= w_bad;
        r_done <= w_bad;
      end else if (r_state == S_RELEASE) begin
        r_done <= 1'b1;
      end else if (w_clr_done) begin
        r_done <= 1'b0;
      end
      if (r_state == S_RELEASE) r_count <= r_count + 16'd1;
      if ((r_state == S_CAPTURE) && w_cnt_zero) r_sense <= r_sync2;
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    case (w_idx)
      3'd0:    w_rdata = {28'd0, r_irq_en, r_op, 1'b0};
      3'd1:    w_rdata = {20'd0, r_col, 4'd0, r_row};
      3'd2:    w_rdata = {r_settle, r_pulse_w};
      3'd3:    w_rdata = {28'd0, r_sense, r_err, r_done, w_busy};
      3'd4:    w_rdata = {16'd0, r_count};
      default: w_rdata = 32'd0;
    endcase
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_ack ? w_rdata : 32'd0;
  assign irq       = r_done & r_irq_en;
endmodule

// File: tb/tb_crossbar_wb_ctrl.sv
// Self-checking bench for crossbar_wb_ctrl: register vectors, directed pulse
// sequences and randomized operations checked against timing rules.
module tb_crossbar_wb_ctrl;
  localparam int          ROWS = 8;
  localparam int          COLS = 8;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic            stb, cyc, we;
  logic [3:0]      sel;
  logic [31:0]     adr, wdat, dat_o;
  logic            ack, sense;
  logic [ROWS-1:0] row_sel;
  logic [COLS-1:0] col_sel;
  logic            set_en, rst_en, read_en, irq;

  int n_cmp  = 0;
  int n_fail = 0;
  int m_count;
  logic m_sense;

  crossbar_wb_ctrl #(.ROWS(ROWS), .COLS(COLS), .BASE_ADDR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .sense_i(sense), .row_sel(row_sel), .col_sel(col_sel), .set_en(set_en),
    .rst_en(rst_en), .read_en(read_en), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  idx;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [31:0] rexp;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic exp_ack, output logic [31:0] r);
    int   n;
    logic got;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
    n = 0; got = 1'b0; r = 32'd0;
    while (!got && n < 6) begin
      @(posedge clk); #1;
      n++;
      if (ack) begin got = 1'b1; r = dat_o; end
    end
    if (exp_ack) begin
      check("ack_latency", got ? n : 99, 1);
      if (got) begin
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        check("ack_width", {31'd0, ack}, 0);
      end else begin
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
      end
    end else begin
      check("no_ack", {31'd0, got}, 0);
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
    end
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    wb_xfer(1'b1, BASE + {27'd0, idx, 2'b00}, d, s, 1'b1, dummy);
  endtask

  task automatic rd(input logic [2:0] idx, output logic [31:0] r);
    wb_xfer(1'b0, BASE + {27'd0, idx, 2'b00}, 32'd0, 4'hF, 1'b1, r);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] idx, input logic [31:0] exp);
    logic [31:0] r;
    rd(idx, r);
    check(name, r, exp);
  endtask

  // Watch the array-side outputs for 40 cycles starting now.
  task automatic monitor(input logic [1:0] op, input logic [3:0] row, input logic [3:0] col,
                         output int en_cnt, output int first_en, output int last_en,
                         output int span, output int bad);
    logic [ROWS-1:0] one_r;
    logic [COLS-1:0] one_c;
    logic [2:0]      mask, ens;
    one_r = 1; one_c = 1;
    mask = (op == 2'd0) ? 3'b001 : (op == 2'd1) ? 3'b100 : (op == 2'd2) ? 3'b010 : 3'b000;
    en_cnt = 0; first_en = -1; last_en = -1; span = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      ens = {set_en, rst_en, read_en};
      if ((ens & mask) != 3'b000) begin
        if (first_en < 0) first_en = i;
        last_en = i;
        en_cnt++;
        if (row_sel == '0) bad++;
      end
      if ((ens & ~mask) != 3'b000) bad++;
      if (row_sel != '0 || col_sel != '0) begin
        span++;
        if (row_sel != (one_r << row) || col_sel != (one_c << col)) bad++;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] r;
    int en_cnt, first_en, last_en, span, bad;

    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
    adr = 32'd0; wdat = 32'd0; sense = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {ack, dat_o != 0, row_sel != 0, col_sel != 0, set_en, rst_en, read_en, irq}, 0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 5; i++) rd_chk("reset_reg", 3'(i), 32'd0);

    // Register access vectors: write, then read back.
    vecs[0]  = '{3'd2, 32'h0003_0005, 4'b0011, 32'h0000_0005};
    vecs[1]  = '{3'd2, 32'hAAAA_BBBB, 4'b1100, 32'hAAAA_0005};
    vecs[2]  = '{3'd2, 32'h1234_5678, 4'b0110, 32'hAA34_5605};
    vecs[3]  = '{3'd1, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0F0F};
    vecs[4]  = '{3'd1, 32'h0000_0203, 4'b0001, 32'h0000_0F03};
    vecs[5]  = '{3'd0, 32'h0000_000A, 4'b0001, 32'h0000_000A};
    vecs[6]  = '{3'd0, 32'h0000_FF00, 4'b0010, 32'h0000_000A};
    vecs[7]  = '{3'd0, 32'h0000_0006, 4'b0001, 32'h0000_0006};
    vecs[8]  = '{3'd3, 32'hFFFF_FFFE, 4'b1111, 32'h0000_0000};
    vecs[9]  = '{3'd4, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000};
    vecs[10] = '{3'd5, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000};
    vecs[11] = '{3'd7, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000};
    for (int i = 0; i < 12; i++) begin
      wr(vecs[i].idx, vecs[i].wdat, vecs[i].sel);
      rd_chk("reg_vector", vecs[i].idx, vecs[i].rexp);
    end
    wb_xfer(1'b0, 32'h3000_0100, 32'd0, 4'hF, 1'b0, r);
    wb_xfer(1'b1, 32'h4000_0000, 32'hFFFF_FFFF, 4'hF, 1'b0, r);

    // SET row 2 col 5, settle 3, pulse 5
    wr(3'd2, 32'h0003_0005, 4'hF);
    wr(3'd1, 32'h0000_0502, 4'hF);
    wr(3'd0, 32'h0000_0003, 4'h1);
    check("set_row_sel", {24'd0, row_sel}, 32'h04);
    check("set_col_sel", {24'd0, col_sel}, 32'h20);
    monitor(2'd1, 4'd2, 4'd5, en_cnt, first_en, last_en, span, bad);
    check("set_first_en", first_en, 3);
    check("set_en_cycles", en_cnt, 5);
    check("set_en_contig", last_en, 7);
    check("set_sel_span", span, 9);
    check("set_bad", bad, 0);
    rd_chk("set_status", 3'd3, 32'h2);
    rd_chk("set_count", 3'd4, 32'd1);

    // READ with sense high, zero timing, irq enabled
    sense = 1'b1;
    wr(3'd2, 32'd0, 4'hF);
    wr(3'd1, 32'h0000_0304, 4'hF);
    wr(3'd0, 32'h0000_0009, 4'h1);
    monitor(2'd0, 4'd4, 4'd3, en_cnt, first_en, last_en, span, bad);
    check("read_en_cycles", en_cnt, 3);
    check("read_first_en", first_en, 1);
    check("read_sel_span", span, 5);
    check("read_bad", bad, 0);
    check("read_irq", {31'd0, irq}, 1);
    rd_chk("read_status", 3'd3, 32'hA);
    wr(3'd3, 32'h0000_0002, 4'h1);
    check("irq_cleared", {31'd0, irq}, 0);
    rd_chk("status_after_clr", 3'd3, 32'h8);

    // Error starts: illegal op, then row out of range
    wr(3'd1, 32'h0000_0101, 4'hF);
    wr(3'd0, 32'h0000_000F, 4'h1);
    check("err_op_irq", {31'd0, irq}, 1);
    monitor(2'd3, 4'd1, 4'd1, en_cnt, first_en, last_en, span, bad);
    check("err_op_quiet", span + bad, 0);
    rd_chk("err_op_status", 3'd3, 32'hE);
    wr(3'd3, 32'h0000_0002, 4'h1);
    check("err_clr_irq", {31'd0, irq}, 0);
    wr(3'd1, 32'h0000_0008, 4'hF);
    wr(3'd0, 32'h0000_000B, 4'h1);
    check("err_row_irq", {31'd0, irq}, 1);
    monitor(2'd1, 4'd8, 4'd0, en_cnt, first_en, last_en, span, bad);
    check("err_row_quiet", span + bad + en_cnt, 0);
    rd_chk("err_row_status", 3'd3, 32'hE);
    rd_chk("err_count", 3'd4, 32'd2);

    // Writes while busy are acked but discarded
    wr(3'd2, 32'h000A_0003, 4'hF);
    wr(3'd1, 32'h0000_0101, 4'hF);
    wr(3'd0, 32'h0000_0003, 4'h1);
    check("busy_row_sel", {24'd0, row_sel}, 32'h02);
    wr(3'd1, 32'h0000_0303, 4'hF);
    wr(3'd0, 32'h0000_0005, 4'h1);
    wr(3'd2, 32'h0000_0000, 4'hF);
    check("busy_row_hold", {24'd0, row_sel}, 32'h02);
    monitor(2'd1, 4'd1, 4'd1, en_cnt, first_en, last_en, span, bad);
    check("busy_set_cycles", en_cnt, 3);
    check("busy_bad", bad, 0);
    rd_chk("busy_addr", 3'd1, 32'h0000_0101);
    rd_chk("busy_timing", 3'd2, 32'h000A_0003);
    rd_chk("busy_ctrl", 3'd0, 32'h2);
    rd_chk("busy_count", 3'd4, 32'd3);

    // Randomized operations against the timing rules
    m_count = 3; m_sense = 1'b1;
    for (int t = 0; t < 40; t++) begin
      logic [1:0] op; logic [3:0] row, col; logic [15:0] s, p; logic sv, ien, bad_op;
      int s1, p1, en_exp;
      op  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      row = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      col = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      s   = 16'($urandom_range(0, 4));
      p   = 16'($urandom_range(0, 4));
      sv  = 1'($urandom_range(0, 1));
      ien = 1'($urandom_range(0, 1));
      sense = sv;
      bad_op = (op == 2'd3) || (row >= 4'(ROWS)) || (col >= 4'(COLS));
      s1 = (s == 0) ? 1 : int'(s);
      p1 = (p == 0) ? 1 : int'(p);
      en_exp = bad_op ? 0 : p1 + ((op == 2'd0) ? 2 : 0);
      wr(3'd2, {s, p}, 4'hF);
      wr(3'd1, {20'd0, col, 4'd0, row}, 4'hF);
      wr(3'd0, {28'd0, ien, op, 1'b1}, 4'h1);
      monitor(op, row, col, en_cnt, first_en, last_en, span, bad);
      check("rnd_en_cycles", en_cnt, en_exp);
      check("rnd_sel_span", span, bad_op ? 0 : s1 + en_exp + 1);
      check("rnd_bad", bad, 0);
      if (!bad_op) begin
        check("rnd_first_en", first_en, s1);
        check("rnd_last_en", last_en, s1 + en_exp - 1);
        m_count++;
        if (op == 2'd0) m_sense = sv;
      end
      check("rnd_irq", {31'd0, irq}, {31'd0, ien});
      rd_chk("rnd_status", 3'd3, {28'd0, m_sense, bad_op, 1'b1, 1'b0});
      rd_chk("rnd_count", 3'd4, 32'(m_count));
    end

    // COUNT wrap from 0xFFFF
    @(negedge clk); force dut.r_count = 16'hFFFF;
    @(negedge clk); release dut.r_count;
    rd_chk("wrap_pre", 3'd4, 32'h0000_FFFF);
    wr(3'd2, 32'd0, 4'hF);
    wr(3'd1, 32'h0000_0000, 4'hF);
    wr(3'd0, 32'h0000_0003, 4'h1);
    monitor(2'd1, 4'd0, 4'd0, en_cnt, first_en, last_en, span, bad);
    check("wrap_en_cycles", en_cnt, 1);
    rd_chk("wrap_count", 3'd4, 32'd0);

    // Reset in the middle of a SET pulse
    wr(3'd2, 32'h0001_0014, 4'hF);
    wr(3'd1, 32'h0000_0403, 4'hF);
    wr(3'd0, 32'h0000_000B, 4'h1);
    @(posedge clk); #1;
    check("mid_pulse_set_en", {31'd0, set_en}, 1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_drop", {set_en, rst_en, read_en, irq, |row_sel, |col_sel}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 5; i++) rd_chk("post_reset_reg", 3'(i), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
